apb_slave_mem: RTL and testbench

- APB completer (slave) fronting a word-addressed register memory with a parameterised wait-state count.
- Pairs with the team's APB master on the same pclk/presetn domain.
- Decodes setup/access phases from psel/penable, inserts wait states via pready, commits writes, returns read data.
- Flags out-of-range accesses with pslverr.

---
 rtl/apb_slave_mem_if.sv | 25 ++
 rtl/apb_slave_mem.sv | 110 +++++++++++
 tb/tb_apb_slave_mem.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the team's APB master and the register-memory completer.
// pclk/presetn stay outside the bundle as plain ports on each block.
interface apb_slave_mem_if #(
    parameter int ADD_WIDTH = 9,
    parameter int WIDTH     = 32
) ();
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [ADD_WIDTH-1:0] paddr;
    logic [WIDTH-1:0]     pwdata;
    logic [WIDTH-1:0]     prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer in front of a word-addressed register memory, with a fixed
// number of wait states before pready and pslverr on out-of-range words.
module apb_slave_mem #(
    parameter int ADD_WIDTH   = 9,
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            pclk,
    input  logic            presetn,
    apb_slave_mem_if.slave  apb
);
    localparam int IW = ADD_WIDTH - 1;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX  = CW'(WAIT_CYCLES);
    localparam logic [IW:0]   DEPTH_LIM = (IW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'b01,
        ACCESS = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_count;
    logic [MW-1:0]    r_idx;
    logic             r_write;
    logic             r_valid;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_prdata;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [IW-1:0]    w_idx;
    logic             w_setup;
    logic             w_access;
    logic             w_valid;
    logic             w_pready;
    logic             w_unused;

    // The address MSB selects this slave on the master side, so it is not decoded.
    assign w_unused = apb.paddr[ADD_WIDTH-1];

    assign w_idx    = apb.paddr[IW-1:0];
    assign w_setup  = apb.psel && !apb.penable;
    assign w_access = apb.psel && apb.penable;
    assign w_valid  = ({1'b0, w_idx} < DEPTH_LIM);
    assign w_pready = (r_state == ACCESS) && (r_count == WAIT_MAX) && w_access;

    assign apb.prdata  = r_prdata;
    assign apb.pready  = w_pready;
    assign apb.pslverr = w_pready && !r_valid;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE: begin
                w_next = w_setup ? ACCESS : IDLE;
            end
            ACCESS: begin
                if (!apb.psel || w_pready) begin
                    w_next = IDLE;
                end else begin
                    w_next = ACCESS;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Setup-edge capture, wait counting and the write commit share one register block.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_count  <= '0;
            r_idx    <= '0;
            r_write  <= 1'b0;
            r_valid  <= 1'b0;
            r_wdata  <= '0;
            r_prdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (r_state == IDLE && w_setup) begin
                r_idx    <= w_idx[MW-1:0];
                r_write  <= apb.pwrite;
                r_valid  <= w_valid;
                r_wdata  <= apb.pwdata;
                r_count  <= '0;
                r_prdata <= (!apb.pwrite && w_valid) ? r_mem[w_idx[MW-1:0]] : '0;
            end else if (r_state == ACCESS && w_access && !w_pready && r_count != WAIT_MAX) begin
                r_count <= r_count + 1'b1;
            end

            if (w_pready && r_write && r_valid) begin
                r_mem[r_idx] <= r_wdata;
            end
        end
    end
endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench: one zero-wait and one two-wait instance driven through the
// shared pclk/presetn, with hand-computed expected values.
module tb_apb_slave_mem;
    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    int   checks  = 0;
    int   passes  = 0;

    apb_slave_mem_if #(.ADD_WIDTH(9), .WIDTH(32)) bus0 ();
    apb_slave_mem_if #(.ADD_WIDTH(9), .WIDTH(32)) bus2 ();

    apb_slave_mem #(.ADD_WIDTH(9), .WIDTH(32), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .presetn(presetn), .apb(bus0)
    );
    apb_slave_mem #(.ADD_WIDTH(9), .WIDTH(32), .DEPTH(64), .WAIT_CYCLES(2)) dut2 (
        .pclk(pclk), .presetn(presetn), .apb(bus2)
    );

    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic driveBus(input int sel, input logic s, input logic e, input logic w,
                            input logic [8:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus0.psel = s; bus0.penable = e; bus0.pwrite = w; bus0.paddr = a; bus0.pwdata = d;
        end else begin
            bus2.psel = s; bus2.penable = e; bus2.pwrite = w; bus2.paddr = a; bus2.pwdata = d;
        end
    endtask

    function automatic logic getReady(input int sel);
        return (sel == 0) ? bus0.pready : bus2.pready;
    endfunction

    function automatic logic getErr(input int sel);
        return (sel == 0) ? bus0.pslverr : bus2.pslverr;
    endfunction

    function automatic logic [31:0] getData(input int sel);
        return (sel == 0) ? bus0.prdata : bus2.prdata;
    endfunction

    // Full transfer; returns at the negedge where pready is high, before the completion edge.
    task automatic applyStimulus(input int sel, input logic wr, input logic [8:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output logic err, output int waits);
        int budget;
        waits  = 0;
        budget = 0;
        rdata  = '0;
        err    = 1'b0;
        @(negedge pclk);
        driveBus(sel, 1'b1, 1'b0, wr, addr, wdata);
        @(negedge pclk);
        driveBus(sel, 1'b1, 1'b1, wr, addr, wdata);
        #1;
        while (!getReady(sel) && budget < 20) begin
            waits++;
            budget++;
            @(negedge pclk);
            #1;
        end
        if (!getReady(sel)) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
        end else begin
            rdata = getData(sel);
            err   = getErr(sel);
        end
    endtask

    task automatic goIdle(input int sel);
        @(negedge pclk);
        driveBus(sel, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          wt;

        driveBus(0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
        driveBus(1, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
        repeat (2) @(negedge pclk);
        #1;
        checkOutput("rst_prdata0", bus0.prdata, 32'h0);
        checkOutput("rst_pready0", {31'b0, bus0.pready}, 32'h0);
        checkOutput("rst_pslverr0", {31'b0, bus0.pslverr}, 32'h0);
        checkOutput("rst_prdata2", bus2.prdata, 32'h0);
        checkOutput("rst_pready2", {31'b0, bus2.pready}, 32'h0);
        @(negedge pclk);
        presetn = 1'b1;

        // Zero-wait write then read through the ignored select bit.
        applyStimulus(0, 1'b1, 9'h105, 32'hDEADBEEF, rd, er, wt);
        checkOutput("w0_wr_waits", 32'(wt), 32'd0);
        checkOutput("w0_wr_err", {31'b0, er}, 32'h0);
        applyStimulus(0, 1'b0, 9'h105, 32'h0, rd, er, wt);
        checkOutput("w0_rd_waits", 32'(wt), 32'd0);
        checkOutput("w0_rd_data", rd, 32'hDEADBEEF);
        checkOutput("w0_rd_err", {31'b0, er}, 32'h0);
        goIdle(0);

        // Access strobe without a setup phase must be ignored.
        @(negedge pclk);
        driveBus(0, 1'b1, 1'b1, 1'b0, 9'h001, 32'h0);
        #1;
        checkOutput("viol_ready_a", {31'b0, bus0.pready}, 32'h0);
        @(negedge pclk);
        #1;
        checkOutput("viol_ready_b", {31'b0, bus0.pready}, 32'h0);
        goIdle(0);

        // Back-to-back transfers with no idle cycles.
        applyStimulus(0, 1'b1, 9'h001, 32'h11, rd, er, wt);
        checkOutput("b2b_wr1_waits", 32'(wt), 32'd0);
        applyStimulus(0, 1'b1, 9'h002, 32'h22, rd, er, wt);
        checkOutput("b2b_wr2_waits", 32'(wt), 32'd0);
        applyStimulus(0, 1'b0, 9'h001, 32'h0, rd, er, wt);
        checkOutput("b2b_rd1", rd, 32'h11);
        applyStimulus(0, 1'b0, 9'h002, 32'h0, rd, er, wt);
        checkOutput("b2b_rd2", rd, 32'h22);
        goIdle(0);

        // Index 70 is beyond DEPTH; index 6 would be its aliased word.
        applyStimulus(0, 1'b1, 9'h046, 32'h12345678, rd, er, wt);
        checkOutput("oor_wr_err", {31'b0, er}, 32'h1);
        applyStimulus(0, 1'b0, 9'h046, 32'h0, rd, er, wt);
        checkOutput("oor_rd_err", {31'b0, er}, 32'h1);
        checkOutput("oor_rd_data", rd, 32'h0);
        applyStimulus(0, 1'b0, 9'h006, 32'h0, rd, er, wt);
        checkOutput("oor_alias6", rd, 32'h0);
        checkOutput("oor_alias6_err", {31'b0, er}, 32'h0);
        applyStimulus(0, 1'b0, 9'h105, 32'h0, rd, er, wt);
        checkOutput("oor_keep5", rd, 32'hDEADBEEF);
        goIdle(0);

        // Two wait states on a read after reset.
        applyStimulus(1, 1'b0, 9'h003, 32'h0, rd, er, wt);
        checkOutput("w2_rd_waits", 32'(wt), 32'd2);
        checkOutput("w2_rd_data", rd, 32'h0);
        checkOutput("w2_rd_err", {31'b0, er}, 32'h0);
        goIdle(1);

        // Abort a write after one access cycle.
        @(negedge pclk);
        driveBus(1, 1'b1, 1'b0, 1'b1, 9'h004, 32'hA5A5A5A5);
        @(negedge pclk);
        driveBus(1, 1'b1, 1'b1, 1'b1, 9'h004, 32'hA5A5A5A5);
        #1;
        checkOutput("abort_ready_a", {31'b0, bus2.pready}, 32'h0);
        @(negedge pclk);
        driveBus(1, 1'b0, 1'b0, 1'b1, 9'h004, 32'hA5A5A5A5);
        #1;
        checkOutput("abort_ready_b", {31'b0, bus2.pready}, 32'h0);
        applyStimulus(1, 1'b0, 9'h004, 32'h0, rd, er, wt);
        checkOutput("abort_rd_data", rd, 32'h0);
        checkOutput("abort_rd_waits", 32'(wt), 32'd2);
        goIdle(1);

        applyStimulus(1, 1'b1, 9'h007, 32'h77, rd, er, wt);
        applyStimulus(1, 1'b0, 9'h007, 32'h0, rd, er, wt);
        checkOutput("w2_rd7", rd, 32'h77);
        goIdle(1);

        // Reset during the wait state of a write to index 9.
        @(negedge pclk);
        driveBus(1, 1'b1, 1'b0, 1'b1, 9'h009, 32'h99);
        @(negedge pclk);
        driveBus(1, 1'b1, 1'b1, 1'b1, 9'h009, 32'h99);
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        checkOutput("midrst_ready2", {31'b0, bus2.pready}, 32'h0);
        checkOutput("midrst_prdata2", bus2.prdata, 32'h0);
        checkOutput("midrst_prdata0", bus0.prdata, 32'h0);
        driveBus(1, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        applyStimulus(1, 1'b0, 9'h009, 32'h0, rd, er, wt);
        checkOutput("midrst_rd9", rd, 32'h0);
        applyStimulus(1, 1'b0, 9'h007, 32'h0, rd, er, wt);
        checkOutput("midrst_rd7", rd, 32'h0);
        goIdle(1);
        applyStimulus(0, 1'b0, 9'h105, 32'h0, rd, er, wt);
        checkOutput("midrst_rd5_w0", rd, 32'h0);
        goIdle(0);

        repeat (2) @(negedge pclk);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
